serial_mod_n: RTL and testbench
===============================

SERIAL_MOD_N -- requirements
Module: serial_mod_n

Interface
REQ-001 SHALL have parameter DIVISOR, default 3, modulus applied to the MSB-first serial number; legal range 2..255.
REQ-002 SHALL have parameter FRAME_LEN, default 8, bits per frame; used only when SERIAL_MOD_FRAME_EN is defined; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous start-of-number; discards the running remainder.
REQ-006 SHALL have port in_valid  input  1  qualifies in; a bit is accepted on each rising edge with in_valid=1.
REQ-007 SHALL have port in  input  1  next serial bit, MSB first.
REQ-008 SHALL have port out_r  output  RW  registered running remainder, RW = $clog2(DIVISOR).
REQ-009 SHALL have port out_valid  output  1  registered; high once at least one bit has been accepted since the last reset or clear.
REQ-010 SHALL have port divisible  output  1  registered; equals out_valid AND (out_r == 0).
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse; exists only with SERIAL_MOD_FRAME_EN.

Function
REQ-012 SHALL compute r_next = (2*r + in) mod DIVISOR with a single conditional subtract; 2*r + in < 2*DIVISOR always holds, so no division operator is permitted.
REQ-013 SHALL carry the intermediate 2*r + in in RW+1 bits, so no overflow occurs at DIVISOR = 2^RW-1 or 2^RW.
REQ-014 SHALL update out_r exactly one cycle after an accepted bit, giving latency 1.
REQ-015 SHALL hold out_r, out_valid and divisible unchanged while in_valid=0.
REQ-016 SHALL implement FSM states IDLE (no bit since reset/clear) and RUN; IDLE->RUN on an accepted bit; any state->IDLE on clear without in_valid.
REQ-017 SHALL, when clear and in_valid are high in the same cycle, start a new number with that bit: out_r = in mod DIVISOR, out_valid=1, state RUN.
REQ-018 SHALL, on clear alone, drive out_r=0, out_valid=0 and divisible=0 on the next cycle.
REQ-019 SHALL handle DIVISOR=2 with RW=1, out_r equal to the last accepted bit.

Reset
REQ-020 SHALL, while rst=1, force state=IDLE, out_r=0, out_valid=0, divisible=0, frame_done=0 and the frame counter to 0, independent of clk.
REQ-021 SHALL, on reset asserted mid-stream, discard all prior bits; the first accepted bit after release starts a new number.

Configuration
REQ-022 SHALL, with macro SERIAL_MOD_FRAME_EN defined, count accepted bits.
REQ-023 SHALL, with SERIAL_MOD_FRAME_EN defined, pulse frame_done for one cycle with the final out_r of the frame on the cycle after the FRAME_LEN-th accepted bit.
REQ-024 SHALL, with SERIAL_MOD_FRAME_EN defined, accept the next bit after the frame's final bit as the first bit of a new number, as if clear had been asserted with it.
REQ-025 SHALL, with SERIAL_MOD_FRAME_EN defined, reset the frame counter to 0 on clear, or to 1 on clear together with in_valid.
REQ-026 SHALL, without SERIAL_MOD_FRAME_EN, omit the frame_done port and the counter; numbers are unbounded and end only on clear or rst.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, RUN) and a width helper function rem_width(divisor) in package serial_mod_pkg.
REQ-028 SHALL isolate the combinational remainder step in sub-module mod_n_step, parameter DIVISOR, ports r, in, r_next.

Verification
REQ-029 SHALL cover: DIVISOR=3, bits 1,1,0 (=6) -> out_r 1,0,0; divisible=1 after the third bit.
REQ-030 SHALL cover: DIVISOR=5, bits 1,0,1,1 (=11) -> out_r 1,2,0,1; in_valid=0 gaps inserted between bits leave out_r unchanged.
REQ-031 SHALL cover: DIVISOR=7, eight 1-bits (=255) -> final out_r=3, divisible=0.
REQ-032 SHALL cover: DIVISOR=3, running out_r=2, then clear+in_valid with in=1 -> out_r=1, out_valid=1; clear alone -> out_r=0, out_valid=0.
REQ-033 SHALL cover: rst pulsed asynchronously between clock edges mid-stream -> outputs 0 immediately; a following bit 1 -> out_r=1.
REQ-034 SHALL cover, with SERIAL_MOD_FRAME_EN, FRAME_LEN=4, DIVISOR=3: bits 1,0,0,1 (=9), then 1 -> frame_done pulses once with out_r=0, then out_r=1 for the new frame.

Source files
------------

// File: rtl/serial_mod_pkg.sv
// Package for serial_mod_n: FSM state type and remainder-width helper.
// Optional feature macro used by the top: SERIAL_MOD_FRAME_EN.
package serial_mod_pkg;

    // IDLE: no bit accepted since reset/clear; RUN: a number is in progress.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to hold a remainder 0..divisor-1 (minimum 1).
    function automatic int unsigned rem_width(input int unsigned divisor);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < divisor) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_n_step.sv
// Combinational remainder step: r_next = (2*r + in) mod DIVISOR.
// Ports:
//   r      - current remainder (RW bits)
//   in     - next serial bit
//   r_next - updated remainder (RW bits)
module mod_n_step
    import serial_mod_pkg::*;
#(
    parameter  int unsigned DIVISOR = 3,
    localparam int unsigned RW      = rem_width(DIVISOR)
) (
    input  logic [RW-1:0] r,
    input  logic          in,
    output logic [RW-1:0] r_next
);

    // 2*r + in is below 2*DIVISOR, so one conditional subtract suffices;
    // the extra bit keeps it exact when DIVISOR is 2^RW or 2^RW-1.
    logic [RW:0] sum;

    assign sum    = {r, in};
    assign r_next = (sum >= (RW+1)'(DIVISOR)) ? RW'(sum - (RW+1)'(DIVISOR))
                                              : sum[RW-1:0];

endmodule

// File: rtl/serial_mod_n.sv
// Running remainder of an MSB-first serial number modulo DIVISOR.
// Optional framing enabled by macro SERIAL_MOD_FRAME_EN.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   clear      - synchronous start-of-number (discards running remainder)
//   in_valid   - qualifies in; one bit accepted per cycle when high
//   in         - serial bit, MSB first
//   out_r      - registered running remainder
//   out_valid  - registered; at least one bit accepted since reset/clear
//   divisible  - registered; out_valid and out_r == 0
//   frame_done - one-cycle pulse after the last bit of a frame (framing only)
module serial_mod_n
    import serial_mod_pkg::*;
#(
    parameter  int unsigned DIVISOR   = 3,
    parameter  int unsigned FRAME_LEN = 8,
    localparam int unsigned RW        = rem_width(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic          in,
    output logic [RW-1:0] out_r,
    output logic          out_valid,
    output logic          divisible
`ifdef SERIAL_MOD_FRAME_EN
    ,
    output logic          frame_done
`endif
);

    localparam int unsigned CW = 16;

    // Elaboration-time guard on parameter ranges.
    if (DIVISOR < 2 || DIVISOR > 255 || FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_param
        $error("serial_mod_n: DIVISOR or FRAME_LEN out of range");
    end

    state_t        state;
    state_t        state_next;
    logic          restart_c;
    logic [RW-1:0] base_c;
    logic [RW-1:0] step_c;

`ifdef SERIAL_MOD_FRAME_EN
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next_c;
    logic          frame_full_c;

    // A completed frame makes the next accepted bit start a new number.
    assign frame_full_c = (cnt == CW'(FRAME_LEN));
    assign restart_c    = clear | (state == IDLE) | frame_full_c;
    assign cnt_next_c   = restart_c ? CW'(1) : cnt + CW'(1);
`else
    assign restart_c    = clear | (state == IDLE);
`endif

    // A restarting bit is folded into a zero remainder.
    assign base_c = restart_c ? '0 : out_r;

    mod_n_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .r      (base_c),
        .in     (in),
        .r_next (step_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: an accepted bit wins over a lone clear.
    always_comb begin
        state_next = state;
        if (in_valid) begin
            state_next = RUN;
        end else if (clear) begin
            state_next = IDLE;
        end
    end

    // Remainder and status registers; held while no bit is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r     <= '0;
            out_valid <= 1'b0;
            divisible <= 1'b0;
        end else if (in_valid) begin
            out_r     <= step_c;
            out_valid <= 1'b1;
            divisible <= (step_c == '0);
        end else if (clear) begin
            out_r     <= '0;
            out_valid <= 1'b0;
            divisible <= 1'b0;
        end
    end

`ifdef SERIAL_MOD_FRAME_EN
    // Frame bit counter and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (in_valid) begin
                cnt        <= cnt_next_c;
                frame_done <= (cnt_next_c == CW'(FRAME_LEN));
            end else if (clear) begin
                cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_mod_n.sv
// Testbench for serial_mod_n: four instances (DIVISOR 3, 5, 7, 2) share the
// input stream; a modulo model pushes expected outputs per cycle.
module tb_serial_mod_n;
    import serial_mod_pkg::*;

`ifdef SERIAL_MOD_FRAME_EN
    localparam bit FRAME = 1'b1;
`else
    localparam bit FRAME = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic in_valid;
    logic bit_in;

    logic [1:0] r3;
    logic [2:0] r5;
    logic [2:0] r7;
    logic [0:0] r2;
    logic v3, v5, v7, v2;
    logic d3, d5, d7, d2;
    logic fd3, fd5, fd7, fd2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][7:0] r;
        logic [3:0]      v;
        logic [3:0]      d;
        logic [3:0]      fd;
    } exp_t;

    exp_t sb[$];

    int mr[4];
    int mv[4];
    int mc[4];
    int md[4] = '{3, 5, 7, 2};
    int ml[4] = '{4, 64, 64, 64};

    always #5 clk = ~clk;

`ifdef SERIAL_MOD_FRAME_EN
    serial_mod_n #(.DIVISOR(3), .FRAME_LEN(4)) u3 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r3), .out_valid(v3), .divisible(d3), .frame_done(fd3));
    serial_mod_n #(.DIVISOR(5), .FRAME_LEN(64)) u5 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r5), .out_valid(v5), .divisible(d5), .frame_done(fd5));
    serial_mod_n #(.DIVISOR(7), .FRAME_LEN(64)) u7 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r7), .out_valid(v7), .divisible(d7), .frame_done(fd7));
    serial_mod_n #(.DIVISOR(2), .FRAME_LEN(64)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r2), .out_valid(v2), .divisible(d2), .frame_done(fd2));
`else
    serial_mod_n #(.DIVISOR(3), .FRAME_LEN(4)) u3 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r3), .out_valid(v3), .divisible(d3));
    serial_mod_n #(.DIVISOR(5), .FRAME_LEN(64)) u5 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r5), .out_valid(v5), .divisible(d5));
    serial_mod_n #(.DIVISOR(7), .FRAME_LEN(64)) u7 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r7), .out_valid(v7), .divisible(d7));
    serial_mod_n #(.DIVISOR(2), .FRAME_LEN(64)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(bit_in),
        .out_r(r2), .out_valid(v2), .divisible(d2));
    assign fd3 = 1'b0;
    assign fd5 = 1'b0;
    assign fd7 = 1'b0;
    assign fd2 = 1'b0;
`endif

    // Drive one cycle, push the model's expectation, then pop and compare.
    task automatic cycle(input logic v, input logic b, input logic clr);
        exp_t       e;
        exp_t       x;
        bit         start;
        int         nc;
        logic [7:0] got_r[4];
        logic       got_v[4];
        logic       got_d[4];
        logic       got_f[4];
        clear    = clr;
        in_valid = v;
        bit_in   = b;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            if (v) begin
                start = clr || (FRAME && mc[k] == ml[k]);
                nc    = start ? 1 : mc[k] + 1;
                mr[k] = ((start ? 0 : mr[k]) * 2 + int'(b)) % md[k];
                mv[k] = 1;
                mc[k] = nc;
                e.fd[k] = FRAME && (nc == ml[k]);
            end else if (clr) begin
                mr[k] = 0;
                mv[k] = 0;
                mc[k] = 0;
            end
            e.r[k] = 8'(mr[k]);
            e.v[k] = (mv[k] != 0);
            e.d[k] = (mv[k] != 0) && (mr[k] == 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        bit_in   = 1'b0;
        got_r = '{8'(r3), 8'(r5), 8'(r7), 8'(r2)};
        got_v = '{v3, v5, v7, v2};
        got_d = '{d3, d5, d7, d2};
        got_f = '{fd3, fd5, fd7, fd2};
        x = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_r[k] !== x.r[k]) begin
                errors++;
                $display("FAIL sb_out_r div%0d got %0d exp %0d", md[k], got_r[k], x.r[k]);
            end
            checks++;
            if (got_v[k] !== x.v[k]) begin
                errors++;
                $display("FAIL sb_out_valid div%0d got %b exp %b", md[k], got_v[k], x.v[k]);
            end
            checks++;
            if (got_d[k] !== x.d[k]) begin
                errors++;
                $display("FAIL sb_divisible div%0d got %b exp %b", md[k], got_d[k], x.d[k]);
            end
            if (FRAME) begin
                checks++;
                if (got_f[k] !== x.fd[k]) begin
                    errors++;
                    $display("FAIL sb_frame_done div%0d got %b exp %b", md[k], got_f[k], x.fd[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({r3, r5, r7, r2, v3, v5, v7, v2, d3, d5, d7, d2, fd3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {r3, r5, r7, r2, v3, v5, v7, v2, d3, d5, d7, d2, fd3});
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mr[k] = 0; mv[k] = 0; mc[k] = 0;
        end
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_div3();
        logic [1:0] tab[3] = '{2'd1, 2'd0, 2'd0};
        logic       bits[3] = '{1'b1, 1'b1, 1'b0};
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, bits[i], 1'b0);
            checks++;
            if (r3 !== tab[i]) begin
                errors++;
                $display("FAIL div3_out_r bit%0d got %0d exp %0d", i, r3, tab[i]);
            end
        end
        checks++;
        if (d3 !== 1'b1) begin
            errors++;
            $display("FAIL div3_divisible got %b exp 1", d3);
        end
    endtask

    task automatic test_div5_gaps();
        logic [2:0] tab[4] = '{3'd1, 3'd2, 3'd0, 3'd1};
        logic       bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, bits[i], 1'b0);
            checks++;
            if (r5 !== tab[i]) begin
                errors++;
                $display("FAIL div5_out_r bit%0d got %0d exp %0d", i, r5, tab[i]);
            end
            checks++;
            if (r2 !== bits[i]) begin
                errors++;
                $display("FAIL div2_last_bit bit%0d got %0d exp %0d", i, r2, bits[i]);
            end
            cycle(1'b0, ~bits[i], 1'b0);
            checks++;
            if (r5 !== tab[i]) begin
                errors++;
                $display("FAIL div5_gap_hold bit%0d got %0d exp %0d", i, r5, tab[i]);
            end
        end
    endtask

    task automatic test_div7_ones();
        cycle(1'b0, 1'b0, 1'b1);
        repeat (8) cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (r7 !== 3'd3 || d7 !== 1'b0) begin
            errors++;
            $display("FAIL div7_255 got r=%0d d=%b exp r=3 d=0", r7, d7);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (r3 !== 2'd2) begin
            errors++;
            $display("FAIL clear_pre got %0d exp 2", r3);
        end
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (r3 !== 2'd1 || v3 !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_bit got r=%0d v=%b exp r=1 v=1", r3, v3);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (r3 !== 2'd0 || v3 !== 1'b0 || d3 !== 1'b0) begin
            errors++;
            $display("FAIL clear_alone got r=%0d v=%b d=%b exp 0 0 0", r3, v3, d3);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({r3, r5, r7, r2, v3, v5, v7, v2, d3, d5, d7, d2, fd3} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", {r3, r5, r7, r2, v3, v5, v7, v2, d3, d5, d7, d2, fd3});
        end
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mr[k] = 0; mv[k] = 0; mc[k] = 0;
        end
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (r3 !== 2'd1 || r5 !== 3'd1 || r7 !== 3'd1 || v3 !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_bit got r3=%0d r5=%0d r7=%0d v3=%b exp 1 1 1 1", r3, r5, r7, v3);
        end
    endtask

    task automatic test_frame();
        logic bits[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   pulses;
        pulses = 0;
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, bits[i], 1'b0);
            if (fd3 === 1'b1) pulses++;
        end
        checks++;
        if (fd3 !== 1'b1 || r3 !== 2'd0) begin
            errors++;
            $display("FAIL frame_end got fd=%b r=%0d exp fd=1 r=0", fd3, r3);
        end
        cycle(1'b1, 1'b1, 1'b0);
        if (fd3 === 1'b1) pulses++;
        checks++;
        if (fd3 !== 1'b0 || r3 !== 2'd1) begin
            errors++;
            $display("FAIL frame_next got fd=%b r=%0d exp fd=0 r=1", fd3, r3);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL frame_pulse_count got %0d exp 1", pulses);
        end
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        bit_in   = 1'b0;
        test_reset();
        test_div3();
        test_div5_gaps();
        test_div7_ones();
        test_clear();
        test_async_reset();
        if (FRAME) test_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
